// File: rtl/radar_median_filter_ch.sv
// Sliding-window per-axis signed median filter for radar point streams.
// Ports: clk/rst (sync, active-high), flush, mode, thresh,
//   in_valid/in_ready/in_point, out_valid/out_ready/out_point/out_filtered.
module radar_median_filter_ch #(
    parameter int POINT_W   = 128,
    parameter int COORD_W   = 32,
    parameter int NUM_AXES  = 3,
    parameter int WIN_DEPTH = 5,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [1:0]         mode,
    input  logic [COORD_W-1:0] thresh,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [POINT_W-1:0] in_point,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [POINT_W-1:0] out_point,
    output logic               out_filtered
);

    localparam int MID = WIN_DEPTH / 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIN_DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        OUT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_sh;
    logic [CNT_W-1:0]   pass_q;
    logic [POINT_W-1:0] point_q;
    logic [1:0]         mode_q;
    logic [COORD_W-1:0] thresh_q;
    logic [POINT_W-1:0] comp_point;

    logic [COORD_W-1:0] win_q  [WIN_DEPTH][NUM_AXES];
    logic [COORD_W-1:0] win_sh [WIN_DEPTH][NUM_AXES];
    logic [COORD_W-1:0] srt_q  [WIN_DEPTH][NUM_AXES];
    logic [COORD_W-1:0] srt_nx [WIN_DEPTH][NUM_AXES];

    // Per-axis output value; outlier test uses a one-bit-wider
    // signed difference so extreme operands cannot overflow.
    function automatic logic [COORD_W-1:0] pick(
        input logic [COORD_W-1:0] raw,
        input logic [COORD_W-1:0] med,
        input logic [1:0]         md,
        input logic [COORD_W-1:0] th
    );
        logic [COORD_W:0] diff;
        logic [COORD_W:0] mag;
        diff = {raw[COORD_W-1], raw} - {med[COORD_W-1], med};
        mag  = diff[COORD_W] ? -diff : diff;
        unique case (md)
            2'b00:   pick = raw;
            2'b10:   pick = (mag > {1'b0, th}) ? med : raw;
            default: pick = med;
        endcase
    endfunction

    // Window as it will look after accepting in_point this cycle.
    // A simultaneous flush empties the older slots first.
    always_comb begin
        for (int i = 0; i < WIN_DEPTH; i++) begin
            for (int a = 0; a < NUM_AXES; a++) begin
                if (i == 0) begin
                    win_sh[i][a] = in_point[COORD_W*a +: COORD_W];
                end else if (flush) begin
                    win_sh[i][a] = '0;
                end else begin
                    win_sh[i][a] = win_q[i-1][a];
                end
            end
        end
        if (flush) begin
            cnt_sh = ONE;
        end else if (cnt_q == FULL) begin
            cnt_sh = FULL;
        end else begin
            cnt_sh = cnt_q + ONE;
        end
    end

    // One odd-even transposition pass; pairs are disjoint so every
    // compare-swap reads the registered copy.
    always_comb begin
        srt_nx = srt_q;
        for (int i = 0; i < WIN_DEPTH - 1; i++) begin
            if (i[0] == pass_q[0]) begin
                for (int a = 0; a < NUM_AXES; a++) begin
                    if ($signed(srt_q[i][a]) > $signed(srt_q[i+1][a])) begin
                        srt_nx[i][a]   = srt_q[i+1][a];
                        srt_nx[i+1][a] = srt_q[i][a];
                    end
                end
            end
        end
    end

    // Bits above the filtered axes stay as the latched raw point.
    always_comb begin
        comp_point = point_q;
        for (int a = 0; a < NUM_AXES; a++) begin
            comp_point[COORD_W*a +: COORD_W] =
                pick(point_q[COORD_W*a +: COORD_W], srt_nx[MID][a],
                     mode_q, thresh_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt_q        <= '0;
            pass_q       <= '0;
            point_q      <= '0;
            mode_q       <= 2'b00;
            thresh_q     <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_point    <= '0;
            out_filtered <= 1'b0;
            for (int i = 0; i < WIN_DEPTH; i++) begin
                for (int a = 0; a < NUM_AXES; a++) begin
                    win_q[i][a] <= '0;
                    srt_q[i][a] <= '0;
                end
            end
        end else begin
            if (flush) begin
                cnt_q <= '0;
                for (int i = 0; i < WIN_DEPTH; i++) begin
                    for (int a = 0; a < NUM_AXES; a++) begin
                        win_q[i][a] <= '0;
                    end
                end
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        win_q    <= win_sh;
                        srt_q    <= win_sh;
                        cnt_q    <= cnt_sh;
                        pass_q   <= '0;
                        point_q  <= in_point;
                        mode_q   <= mode;
                        thresh_q <= thresh;
                        in_ready <= 1'b0;
                        if (cnt_sh == FULL && mode != 2'b00) begin
                            state <= SORT;
                        end else begin
                            state        <= OUT;
                            out_valid    <= 1'b1;
                            out_point    <= in_point;
                            out_filtered <= 1'b0;
                        end
                    end
                end
                SORT: begin
                    srt_q  <= srt_nx;
                    pass_q <= pass_q + ONE;
                    if (pass_q == LAST) begin
                        state        <= OUT;
                        out_valid    <= 1'b1;
                        out_point    <= comp_point;
                        out_filtered <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radar_median_filter_ch.sv
// Directed bench for radar_median_filter_ch (WIN_DEPTH=5, 3 axes).
// Expected points are hand-computed medians over the window contents.
module tb_radar_median_filter_ch;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [1:0]   mode;
    logic [31:0]  thresh;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_point;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_point;
    logic         out_filtered;

    int checks = 0;
    int errors = 0;

    radar_median_filter_ch dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .mode        (mode),
        .thresh      (thresh),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_point    (in_point),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_point   (out_point),
        .out_filtered(out_filtered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk(
        input logic [31:0] up,
        input logic [31:0] z,
        input logic [31:0] y,
        input logic [31:0] x
    );
        return {up, z, y, x};
    endfunction

    task automatic chk(
        input string        tag,
        input logic [127:0] obs,
        input logic [127:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one point, measure latency, check result, hold out_ready
    // low for 'hold' cycles, then complete the transfer.
    task automatic send(
        input string        tag,
        input logic [127:0] pt,
        input logic [1:0]   md,
        input logic [31:0]  th,
        input logic         fl,
        input int           hold,
        input int           exp_lat,
        input logic [127:0] exp_pt,
        input logic         exp_f
    );
        int lat;
        out_ready = (hold == 0);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        in_point = pt;
        mode     = md;
        thresh   = th;
        flush    = fl;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        mode     = 2'b00;
        thresh   = '1;
        in_point = '0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_point"}, out_point, exp_pt);
        chk({tag, "_filt"}, 128'(out_filtered), 128'(exp_f));
        chk({tag, "_busy"}, 128'(in_ready), 128'(0));
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({tag, "_hold_v"}, 128'(out_valid), 128'(1));
            chk({tag, "_hold_p"}, out_point, exp_pt);
            chk({tag, "_hold_r"}, 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        tick();
        chk({tag, "_done_v"}, 128'(out_valid), 128'(0));
        chk({tag, "_done_r"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        flush     = 1'b0;
        mode      = 2'b01;
        thresh    = '0;
        in_valid  = 1'b1;
        in_point  = mk(32'h1, 32'h2, 32'h3, 32'h4);
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_point", out_point, 128'(0));
        chk("rst_out_filt", 128'(out_filtered), 128'(0));
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_no_accept", 128'(out_valid), 128'(0));

        // Warm-up then first full window, mode 01
        for (int i = 1; i <= 4; i++) begin
            send($sformatf("warm%0d", i),
                 mk(32'hDEADBEEF, 32'(-i), 32'(10 * i), 32'(i)),
                 2'b01, 32'd0, 1'b0, 0, 1,
                 mk(32'hDEADBEEF, 32'(-i), 32'(10 * i), 32'(i)), 1'b0);
        end
        send("med5", mk(32'h12345678, 32'd0, -32'sd7, 32'd100),
             2'b01, 32'd0, 1'b0, 0, 6,
             mk(32'h12345678, -32'sd2, 32'd20, 32'd3), 1'b1);

        // Flush alone, then outlier mode rebuild
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send($sformatf("ow%0d", i), mk(32'd0, 32'd0, 32'd0, 32'(i)),
                 2'b10, 32'd10, 1'b0, 0, 1,
                 mk(32'd0, 32'd0, 32'd0, 32'(i)), 1'b0);
        end
        send("out50", mk(32'd0, 32'd0, 32'd0, 32'd50),
             2'b10, 32'd10, 1'b0, 0, 6,
             mk(32'd0, 32'd0, 32'd0, 32'd2), 1'b1);
        send("out4", mk(32'hA5A5A5A5, 32'd5, 32'd100, 32'd4),
             2'b10, 32'd10, 1'b0, 0, 6,
             mk(32'hA5A5A5A5, 32'd5, 32'd0, 32'd4), 1'b1);

        // Bypass with a full window, then mode 11 as median
        send("byp", mk(32'd0, 32'd0, 32'd0, 32'd77),
             2'b00, 32'd0, 1'b0, 0, 1,
             mk(32'd0, 32'd0, 32'd0, 32'd77), 1'b0);
        send("m11", mk(32'd0, 32'd0, 32'd0, 32'd60),
             2'b11, 32'd0, 1'b0, 0, 6,
             mk(32'd0, 32'd0, 32'd0, 32'd50), 1'b1);

        // Flush with accept in the same cycle, then signed window
        send("fl_acc", mk(32'hCAFEF00D, 32'd0, 32'h80000000, -32'sd5),
             2'b01, 32'd0, 1'b1, 0, 1,
             mk(32'hCAFEF00D, 32'd0, 32'h80000000, -32'sd5), 1'b0);
        send("sg1", mk(32'hCAFEF00D, 32'd0, 32'h7FFFFFFF, -32'sd3),
             2'b01, 32'd0, 1'b0, 0, 1,
             mk(32'hCAFEF00D, 32'd0, 32'h7FFFFFFF, -32'sd3), 1'b0);
        send("sg2", mk(32'hCAFEF00D, 32'd0, 32'd1, 32'd0),
             2'b01, 32'd0, 1'b0, 0, 1,
             mk(32'hCAFEF00D, 32'd0, 32'd1, 32'd0), 1'b0);
        send("sg3", mk(32'hCAFEF00D, 32'd0, 32'hFFFFFFFF, 32'd7),
             2'b01, 32'd0, 1'b0, 0, 1,
             mk(32'hCAFEF00D, 32'd0, 32'hFFFFFFFF, 32'd7), 1'b0);
        send("sgmed", mk(32'hCAFEF00D, 32'd0, 32'h80000000, 32'h7FFFFFFF),
             2'b01, 32'd0, 1'b0, 0, 6,
             mk(32'hCAFEF00D, 32'd0, 32'hFFFFFFFF, 32'd0), 1'b1);

        // Backpressure for 8 cycles in OUT
        send("bp", mk(32'h0BADCAFE, 32'd0, 32'd5, -32'sd4),
             2'b01, 32'd0, 1'b0, 8, 6,
             mk(32'h0BADCAFE, 32'd0, 32'd1, 32'd0), 1'b1);

        // Reset while sorting discards the point
        in_point = mk(32'd0, 32'd0, 32'd0, 32'd1000);
        mode     = 2'b01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("sort_busy", 128'(in_ready), 128'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_sort_ready", 128'(in_ready), 128'(1));
        chk("rst_sort_valid", 128'(out_valid), 128'(0));
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("rst_sort_never", 128'(seen), 128'(0));
        send("post_rst", mk(32'd0, 32'd0, 32'd0, 32'd42),
             2'b01, 32'd0, 1'b0, 0, 1,
             mk(32'd0, 32'd0, 32'd0, 32'd42), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
